stdp_pair_controller: RTL and testbench
=======================================

// Module: stdp_pair_controller
// PURPOSE
//  Sequences spike-timing-dependent plasticity between one presynaptic and one postsynaptic LIF neuron.
//  Watches both spike lines, times the pre/post interval with a window counter, and classifies each pair
//  as potentiation (LTP) or depression (LTD). Applies a decaying, saturating update to the synaptic weight
//  register. Sits between the two lif instances and the weight consumer, i.e. it is the sequencing
//  controller for the spiking datapath.
// PARAMETERS
//  W_WIDTH    8    weight register width (unsigned)
//  T_WIDTH    4    interval counter / time_diff width
//  WINDOW     15   max pairing interval in cycles (1..2**T_WIDTH-1)
//  A_PLUS     16   LTP amplitude at dt shift 0
//  A_MINUS    16   LTD amplitude at dt shift 0
//  TAU_SHIFT  2    amplitude halves every 2**TAU_SHIFT cycles of dt
//  W_INIT     128  weight value after reset
// PORTS
//  clk            in   1        clock; all state on rising edge
//  rst            in   1        synchronous reset, active-high
//  learn_en       in   1        1 = plasticity enabled; 0 = FSM forced IDLE, weight held
//  pre_spike      in   1        presynaptic spike; every high cycle is one spike event
//  post_spike     in   1        postsynaptic spike; every high cycle is one spike event
//  weight         out  W_WIDTH  current synaptic weight (registered)
//  time_diff      out  T_WIDTH  dt of last classified pair (registered, held until next pair)
//  update_w_flag  out  1        one-cycle pulse in the cycle weight takes its new value
//  ltp            out  1        with update_w_flag: 1 = potentiation, 0 = depression
//  busy           out  1        1 whenever state != IDLE
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, cnt=0, weight=W_INIT, time_diff=0, update_w_flag=0, ltp=0. rst overrides
//   everything, including mid-pair or in UPDATE; no partial update is applied.
//  States: IDLE, PRE_ARMED, POST_ARMED, UPDATE.
//  IDLE: pre&post same cycle -> stay IDLE, no update (dt=0 is ambiguous). pre only -> PRE_ARMED, cnt=0.
//   post only -> POST_ARMED, cnt=0.
//  PRE_ARMED: each cycle cnt++. post seen -> time_diff=cnt+1, ltp=1, -> UPDATE (pre same cycle ignored).
//   pre only -> re-arm, cnt=0 (most recent pre wins). No spike and cnt+1 == WINDOW -> IDLE, no update.
//  POST_ARMED: mirror image: pre closes pair with ltp=0 (LTD); post re-arms; timeout -> IDLE.
//  UPDATE: exactly one cycle; spikes in this cycle are ignored. Next edge: weight updated, update_w_flag=1
//   for that one cycle, state -> IDLE.
//  Latency: closing spike sampled at edge k -> UPDATE after k; new weight and flag visible after edge k+1.
//  Arithmetic: s = time_diff >> TAU_SHIFT; delta = (s >= W_WIDTH) ? 0 : A >> s (A = A_PLUS or A_MINUS).
//   LTP: weight = min(weight+delta, 2**W_WIDTH-1); LTD: weight = max(weight-delta, 0). Computed at
//   W_WIDTH+1 bits; never wraps. delta=0 still pulses update_w_flag.
//  learn_en=0: next edge forces IDLE, cnt=0; weight/time_diff held; no flag. If deasserted in UPDATE the
//   update is dropped.
// STRUCTURE
//  stdp_pkg: state enum (stdp_state_t), default constants (W_WIDTH, T_WIDTH, WINDOW, W_INIT, TAU_SHIFT).
//  Sub-module stdp_weight_update: combinational dt->delta shift plus saturating add/sub; FSM, counter and
//   registers stay in stdp_pair_controller.
// TESTING (defaults unless stated)
//  1 rst=1 two cycles, then idle 5 cycles -> weight=128, time_diff=0, update_w_flag=0, busy=0.
//  2 pre at cycle 0, post at cycle 3 -> time_diff=3, ltp=1, delta=16, weight=144, flag high exactly 1 cycle
//    at cycle 5.
//  3 post at cycle 0, pre at cycle 9 -> time_diff=9, s=2, delta=4, ltp=0, weight=124.
//  4 pre&post same cycle from IDLE -> busy stays 0, no flag, weight=128. pre then no post for 15 cycles ->
//    back to IDLE, no flag; post 1 cycle later -> POST_ARMED (busy=1).
//  5 eight LTP pairs with dt=1 from 128 -> weight 144..240, then 255 (saturated, no wrap); then pairs of LTD
//    to 0 -> stays 0.
//  6 rst asserted in UPDATE cycle of a pair -> weight=128, no flag; learn_en=0 during PRE_ARMED -> IDLE,
//    weight unchanged.

Source files
------------

// File: rtl/stdp_pkg.sv
// Shared types and default constants for the STDP pair controller slice.
package stdp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE_ARMED,
    ST_POST_ARMED,
    ST_UPDATE
  } stdp_state_t;

  localparam int unsigned STDP_W_WIDTH   = 8;
  localparam int unsigned STDP_T_WIDTH   = 4;
  localparam int unsigned STDP_WINDOW    = 15;
  localparam int unsigned STDP_A_PLUS    = 16;
  localparam int unsigned STDP_A_MINUS   = 16;
  localparam int unsigned STDP_TAU_SHIFT = 2;
  localparam int unsigned STDP_W_INIT    = 128;

endpackage

// File: rtl/stdp_pair_controller_weight_update.sv
// Combinational weight update: dt -> decayed amplitude, then saturating add/sub.
module stdp_weight_update
  import stdp_pkg::*;
#(
  parameter int unsigned W_WIDTH   = STDP_W_WIDTH,
  parameter int unsigned T_WIDTH   = STDP_T_WIDTH,
  parameter int unsigned A_PLUS    = STDP_A_PLUS,
  parameter int unsigned A_MINUS   = STDP_A_MINUS,
  parameter int unsigned TAU_SHIFT = STDP_TAU_SHIFT
) (
  input  logic [W_WIDTH-1:0] weight,
  input  logic [T_WIDTH-1:0] time_diff,
  input  logic               ltp,
  output logic [W_WIDTH-1:0] weight_next
);

  localparam logic [W_WIDTH:0] AMP_P = (W_WIDTH+1)'(A_PLUS);
  localparam logic [W_WIDTH:0] AMP_M = (W_WIDTH+1)'(A_MINUS);
  localparam logic [W_WIDTH:0] W_MAX = {1'b0, {W_WIDTH{1'b1}}};

  logic [T_WIDTH-1:0] shift;
  logic [W_WIDTH:0]   delta;
  logic [W_WIDTH:0]   sum;

  // Amplitude halves every 2**TAU_SHIFT cycles of dt; result is clamped to the weight range.
  always_comb begin
    shift       = time_diff >> TAU_SHIFT;
    delta       = '0;
    sum         = '0;
    weight_next = weight;
    if (32'(shift) < W_WIDTH) begin
      delta = (ltp ? AMP_P : AMP_M) >> shift;
    end
    if (ltp) begin
      sum         = {1'b0, weight} + delta;
      weight_next = (sum > W_MAX) ? '1 : sum[W_WIDTH-1:0];
    end else begin
      weight_next = (delta > {1'b0, weight}) ? '0 : W_WIDTH'({1'b0, weight} - delta);
    end
  end

endmodule

// File: rtl/stdp_pair_controller.sv
// Pre/post spike pairing FSM with interval counter and STDP weight register.
module stdp_pair_controller
  import stdp_pkg::*;
#(
  parameter int unsigned W_WIDTH   = STDP_W_WIDTH,
  parameter int unsigned T_WIDTH   = STDP_T_WIDTH,
  parameter int unsigned WINDOW    = STDP_WINDOW,
  parameter int unsigned A_PLUS    = STDP_A_PLUS,
  parameter int unsigned A_MINUS   = STDP_A_MINUS,
  parameter int unsigned TAU_SHIFT = STDP_TAU_SHIFT,
  parameter int unsigned W_INIT    = STDP_W_INIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               learn_en,
  input  logic               pre_spike,
  input  logic               post_spike,
  output logic [W_WIDTH-1:0] weight,
  output logic [T_WIDTH-1:0] time_diff,
  output logic               update_w_flag,
  output logic               ltp,
  output logic               busy
);

  stdp_state_t        state, state_n;
  logic [T_WIDTH-1:0] cnt, cnt_n, cnt_inc;
  logic [T_WIDTH-1:0] time_diff_n;
  logic               ltp_n;
  logic               flag_n;
  logic [W_WIDTH-1:0] weight_n, weight_calc;

  assign cnt_inc = cnt + T_WIDTH'(1);
  assign busy    = (state != ST_IDLE);

  stdp_weight_update #(
    .W_WIDTH   (W_WIDTH),
    .T_WIDTH   (T_WIDTH),
    .A_PLUS    (A_PLUS),
    .A_MINUS   (A_MINUS),
    .TAU_SHIFT (TAU_SHIFT)
  ) u_weight_update (
    .weight      (weight),
    .time_diff   (time_diff),
    .ltp         (ltp),
    .weight_next (weight_calc)
  );

  // State, counter and output registers; reset overrides any pair in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      weight        <= W_WIDTH'(W_INIT);
      time_diff     <= '0;
      update_w_flag <= 1'b0;
      ltp           <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      weight        <= weight_n;
      time_diff     <= time_diff_n;
      update_w_flag <= flag_n;
      ltp           <= ltp_n;
    end
  end

  // Next-state: arm on a lone spike, close on the opposite spike, re-arm on a repeat, time out at WINDOW.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    time_diff_n = time_diff;
    ltp_n       = ltp;
    weight_n    = weight;
    flag_n      = 1'b0;
    if (!learn_en) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt_n = '0;
          if (pre_spike && !post_spike) begin
            state_n = ST_PRE_ARMED;
          end else if (post_spike && !pre_spike) begin
            state_n = ST_POST_ARMED;
          end
        end
        ST_PRE_ARMED: begin
          if (post_spike) begin
            time_diff_n = cnt_inc;
            ltp_n       = 1'b1;
            state_n     = ST_UPDATE;
            cnt_n       = '0;
          end else if (pre_spike) begin
            cnt_n = '0;
          end else if (cnt_inc == T_WIDTH'(WINDOW)) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_POST_ARMED: begin
          if (pre_spike) begin
            time_diff_n = cnt_inc;
            ltp_n       = 1'b0;
            state_n     = ST_UPDATE;
            cnt_n       = '0;
          end else if (post_spike) begin
            cnt_n = '0;
          end else if (cnt_inc == T_WIDTH'(WINDOW)) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        ST_UPDATE: begin
          weight_n = weight_calc;
          flag_n   = 1'b1;
          state_n  = ST_IDLE;
          cnt_n    = '0;
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stdp_pair_controller.sv
// Self-checking bench: directed vector table, hand-written corner sequences, randomized run vs. reference model.
module tb_stdp_pair_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       learn_en = 1'b1;
  logic       pre_spike = 1'b0;
  logic       post_spike = 1'b0;
  logic [7:0] weight;
  logic [3:0] time_diff;
  logic       update_w_flag;
  logic       ltp;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  stdp_pair_controller dut (
    .clk           (clk),
    .rst           (rst),
    .learn_en      (learn_en),
    .pre_spike     (pre_spike),
    .post_spike    (post_spike),
    .weight        (weight),
    .time_diff     (time_diff),
    .update_w_flag (update_w_flag),
    .ltp           (ltp),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit r, e, p, q;
    int reps;
    int w, td, flag, bsy, lt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit e, bit p, bit q, int reps,
                              int w, int td, int flag, int bsy, int lt);
    vec_t v;
    v.r = r; v.e = e; v.p = p; v.q = q; v.reps = reps;
    v.w = w; v.td = td; v.flag = flag; v.bsy = bsy; v.lt = lt;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, settle before sampling.
  task automatic cyc(bit r, bit e, bit p, bit q);
    rst = r; learn_en = e; pre_spike = p; post_spike = q;
    @(posedge clk);
    #1;
  endtask

  // Reference model: pairs tracked by arm timestamp, weight by integer min/max.
  int m_mode, m_arm, m_now, m_w, m_td, m_flag, m_ltp;

  task automatic model_step(bit r, bit e, bit p, bit q);
    int dt, s, d;
    m_now++;
    m_flag = 0;
    if (r) begin
      m_mode = 0; m_w = 128; m_td = 0; m_ltp = 0;
    end else if (!e) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      if (p != q) begin
        m_mode = p ? 1 : 2;
        m_arm  = m_now;
      end
    end else if (m_mode == 3) begin
      s = m_td / 4;
      d = (s >= 8) ? 0 : 16 / (1 << s);
      if (m_ltp == 1) m_w = (m_w + d > 255) ? 255 : m_w + d;
      else            m_w = (m_w - d < 0) ? 0 : m_w - d;
      m_flag = 1;
      m_mode = 0;
    end else begin
      dt = m_now - m_arm;
      if ((m_mode == 1 && q) || (m_mode == 2 && p)) begin
        m_td   = dt;
        m_ltp  = (m_mode == 1) ? 1 : 0;
        m_mode = 3;
      end else if ((m_mode == 1 && p) || (m_mode == 2 && q)) begin
        m_arm = m_now;
      end else if (dt == 15) begin
        m_mode = 0;
      end
    end
  endtask

  task automatic do_pair(bit first_pre, int dt);
    cyc(0, 1, first_pre, !first_pre);
    repeat (dt - 1) cyc(0, 1, 0, 0);
    cyc(0, 1, !first_pre, first_pre);
    cyc(0, 1, 0, 0);
  endtask

  initial begin
    int expw;
    bit r, e, p, q;

    // Directed vectors: {rst, en, pre, post, reps} -> {weight, time_diff, flag, busy, ltp-if-flag}
    tbl.push_back(mk(1, 1, 0, 0, 2,  128, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 5,  128, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1,  128, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 2,  128, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1,  128, 3, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,  144, 3, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1,  144, 3, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 1,  128, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1,  128, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8,  128, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1,  128, 9, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,  124, 9, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 1,  124, 9, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1,  124, 9, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 14, 124, 9, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,  124, 9, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1,  124, 9, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 14, 124, 9, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1,  124, 9, 0, 0, 0));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].reps; k++) begin
        cyc(tbl[i].r, tbl[i].e, tbl[i].p, tbl[i].q);
        chk($sformatf("row%0d.%0d weight", i, k), int'(weight), tbl[i].w);
        chk($sformatf("row%0d.%0d time_diff", i, k), int'(time_diff), tbl[i].td);
        chk($sformatf("row%0d.%0d flag", i, k), int'(update_w_flag), tbl[i].flag);
        chk($sformatf("row%0d.%0d busy", i, k), int'(busy), tbl[i].bsy);
        if (tbl[i].flag == 1) chk($sformatf("row%0d.%0d ltp", i, k), int'(ltp), tbl[i].lt);
      end
    end

    // Saturation: LTP pairs with dt=1 climb by 16 and clamp at 255, LTD pairs floor at 0.
    cyc(1, 1, 0, 0);
    expw = 128;
    for (int k = 0; k < 8; k++) begin
      do_pair(1'b1, 1);
      expw = (expw + 16 > 255) ? 255 : expw + 16;
      chk($sformatf("sat_ltp%0d weight", k), int'(weight), expw);
      chk($sformatf("sat_ltp%0d flag", k), int'(update_w_flag), 1);
    end
    chk("sat_ltp final", int'(weight), 255);
    for (int k = 0; k < 17; k++) begin
      do_pair(1'b0, 1);
      expw = (expw - 16 < 0) ? 0 : expw - 16;
      chk($sformatf("sat_ltd%0d weight", k), int'(weight), expw);
      chk($sformatf("sat_ltd%0d ltp", k), int'(ltp), 0);
    end
    chk("sat_ltd final", int'(weight), 0);

    // Reset landing on the UPDATE cycle discards the pending update.
    cyc(1, 1, 0, 0);
    do_pair(1'b1, 2);
    chk("pre_rst weight", int'(weight), 144);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 1);
    chk("in_update busy", int'(busy), 1);
    cyc(1, 1, 0, 0);
    chk("rst_in_update weight", int'(weight), 128);
    chk("rst_in_update flag", int'(update_w_flag), 0);
    chk("rst_in_update busy", int'(busy), 0);
    cyc(0, 1, 0, 0);
    chk("after_rst flag", int'(update_w_flag), 0);

    // learn_en low while armed forces IDLE with weight held.
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("en_off_armed busy", int'(busy), 0);
    chk("en_off_armed weight", int'(weight), 128);
    cyc(0, 1, 0, 1);
    chk("after_en post busy", int'(busy), 1);
    cyc(0, 1, 0, 0);
    chk("after_en post flag", int'(update_w_flag), 0);
    cyc(0, 0, 0, 0);

    // learn_en low in UPDATE drops the update.
    cyc(0, 1, 0, 1);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    chk("en_off_update weight", int'(weight), 128);
    chk("en_off_update flag", int'(update_w_flag), 0);
    chk("en_off_update busy", int'(busy), 0);

    // Randomized run against the reference model.
    m_now = 0;
    cyc(1, 1, 0, 0);
    model_step(1, 1, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 59) != 0);
      p = ($urandom_range(0, 99) < 10);
      q = ($urandom_range(0, 99) < 10);
      cyc(r, e, p, q);
      model_step(r, e, p, q);
      chk($sformatf("rnd%0d weight", n), int'(weight), m_w);
      chk($sformatf("rnd%0d time_diff", n), int'(time_diff), m_td);
      chk($sformatf("rnd%0d flag", n), int'(update_w_flag), m_flag);
      chk($sformatf("rnd%0d busy", n), int'(busy), (m_mode != 0) ? 1 : 0);
      if (m_flag == 1) chk($sformatf("rnd%0d ltp", n), int'(ltp), m_ltp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
